// File: rtl/cc_local_packetizer.sv
// rtl/cc_local_packetizer.sv - frames one local data burst into a checksummed valid/ready packet
module cc_local_packetizer #(
    parameter logic [7:0] NODE_ID   = 8'h01,
    parameter int         MAX_WORDS = 16
) (
    input  logic        sdi_clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        LocalDataValid,
    input  logic [31:0] LocalCountData,
    input  logic [31:0] LocalBpmPosData,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] overrun_cnt
);

    localparam int         IW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [7:0] MAXW = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_HDR, S_XW, S_YW, S_PAY, S_CSUM
    } state_t;

    state_t      r_state;
    logic        r_prev_valid;
    logic [31:0] r_buf [MAX_WORDS];
    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [31:0] r_sum;
    logic [31:0] r_tx_data;
    logic        r_tx_valid;
    logic        r_tx_last;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_overrun_cnt;

    logic        w_start;
    logic        w_accept;
    logic [31:0] w_sum_next;

    assign w_start    = LocalDataValid & ~r_prev_valid;
    assign w_accept   = r_tx_valid & tx_ready;
    assign w_sum_next = r_sum + r_tx_data;

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign tx_last     = r_tx_last;
    assign busy        = (r_state != S_IDLE);
    assign frame_cnt   = r_frame_cnt;
    assign overrun_cnt = r_overrun_cnt;

    // Count bursts that begin while a previous burst is still being captured or sent
    always_ff @(posedge sdi_clk) begin
        if (Reset) begin
            r_overrun_cnt <= 16'h0;
        end else if (w_start && (r_state != S_IDLE) && (r_overrun_cnt != 16'hFFFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 16'd1;
        end
    end

    // Capture/transmit FSM; the running sum accumulates each word as it is accepted
    always_ff @(posedge sdi_clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_prev_valid <= 1'b0;
            r_len        <= 8'h0;
            r_idx        <= 8'h0;
            r_x          <= 32'h0;
            r_y          <= 32'h0;
            r_sum        <= 32'h0;
            r_tx_data    <= 32'h0;
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_frame_cnt  <= 16'h0;
        end else begin
            r_prev_valid <= LocalDataValid;
            case (r_state)
                S_IDLE: begin
                    if (w_start && Enable) begin
                        r_buf[0] <= LocalCountData;
                        r_x      <= LocalBpmPosData;
                        r_y      <= 32'h0;
                        r_len    <= 8'd1;
                        r_state  <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (LocalDataValid && (r_len != MAXW)) begin
                        r_buf[r_len[IW-1:0]] <= LocalCountData;
                        if (r_len == 8'd1) begin
                            r_y <= LocalBpmPosData;
                        end
                        r_len <= r_len + 8'd1;
                    end else begin
                        // Beats arriving once the buffer is full are simply not stored
                        r_tx_data  <= {8'hA5, NODE_ID, r_len, r_frame_cnt[7:0]};
                        r_tx_valid <= 1'b1;
                        r_sum      <= 32'h0;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_sum     <= w_sum_next;
                        r_tx_data <= r_x;
                        r_state   <= S_XW;
                    end
                end
                S_XW: begin
                    if (w_accept) begin
                        r_sum     <= w_sum_next;
                        r_tx_data <= r_y;
                        r_state   <= S_YW;
                    end
                end
                S_YW: begin
                    if (w_accept) begin
                        r_sum     <= w_sum_next;
                        r_tx_data <= r_buf[0];
                        r_idx     <= 8'd1;
                        r_state   <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_accept) begin
                        r_sum <= w_sum_next;
                        if (r_idx == r_len) begin
                            r_tx_data <= ~w_sum_next + 32'd1;
                            r_tx_last <= 1'b1;
                            r_state   <= S_CSUM;
                        end else begin
                            r_tx_data <= r_buf[r_idx[IW-1:0]];
                            r_idx     <= r_idx + 8'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_tx_data   <= 32'h0;
                        r_tx_valid  <= 1'b0;
                        r_tx_last   <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_local_packetizer.sv
// tb/tb_cc_local_packetizer.sv - self-checking bench for cc_local_packetizer
module tb_cc_local_packetizer;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b1;
    logic        LocalDataValid = 1'b0;
    logic [31:0] LocalCountData = 32'h0;
    logic [31:0] LocalBpmPosData = 32'h0;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] overrun_cnt;

    cc_local_packetizer #(.NODE_ID(8'h01), .MAX_WORDS(MAXW)) dut (
        .sdi_clk(clk), .Reset(Reset), .Enable(Enable),
        .LocalDataValid(LocalDataValid), .LocalCountData(LocalCountData),
        .LocalBpmPosData(LocalBpmPosData), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy),
        .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ready pattern: 0 always 1, 1 = 1,0,0 repeating, 2 random, 3 held low
    int rmode = 0;
    int phase = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = (phase % 3 == 0); phase++; end
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    // monitor: collect accepted words, check stall stability
    logic [31:0] rx_q[$];
    int          n_last = 0;
    int          rx_last_idx = -1;
    int          cyc = 0, first_cyc = 0, last_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        cyc++;
        if (prev_stall && Reset === 1'b0) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", tx_data, prev_data);
            chk("stall_last", 32'(tx_last), 32'(prev_last));
        end
        prev_stall = (tx_valid === 1'b1 && tx_ready === 1'b0 && Reset === 1'b0);
        prev_data  = tx_data;
        prev_last  = tx_last;
        if (tx_valid === 1'b1 && tx_ready === 1'b1 && Reset === 1'b0) begin
            if (rx_q.size() == 0) first_cyc = cyc;
            rx_q.push_back(tx_data);
            if (tx_last === 1'b1) begin
                last_cyc    = cyc;
                rx_last_idx = rx_q.size() - 1;
                n_last++;
            end
        end
    end

    // burst stimulus and reference packet
    logic [31:0] bq[$];
    logic [31:0] bx, by;
    logic [31:0] exp_q[$];
    int          exp_frames = 0;

    task automatic drive_burst(input int n, input bit fixed);
        bq.delete();
        bx = fixed ? 32'h11 : $urandom;
        by = fixed ? 32'h22 : $urandom;
        for (int i = 0; i < n; i++) begin
            logic [31:0] c;
            c = fixed ? 32'(100 + i) : $urandom;
            bq.push_back(c);
            @(posedge clk); #1;
            LocalDataValid  = 1'b1;
            LocalCountData  = c;
            LocalBpmPosData = (i == 0) ? bx : (i == 1) ? by : $urandom;
        end
        @(posedge clk); #1;
        LocalDataValid = 1'b0;
        LocalCountData = $urandom;
    endtask

    task automatic make_exp(input int n, input logic [7:0] fr);
        int m;
        logic [31:0] s;
        m = (n > MAXW) ? MAXW : n;
        exp_q.delete();
        exp_q.push_back({8'hA5, 8'h01, 8'(m), fr});
        exp_q.push_back(bx);
        exp_q.push_back((n > 1) ? by : 32'h0);
        for (int i = 0; i < m; i++) exp_q.push_back(bq[i]);
        s = 32'h0;
        foreach (exp_q[i]) s = s + exp_q[i];
        exp_q.push_back(32'h0 - s);
    endtask

    task automatic wait_last(input string tag, input int budget);
        int start, k;
        start = n_last;
        k = 0;
        while (n_last == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_last == start) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_packet(input string tag);
        logic [31:0] s;
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx, exp_q[i]);
        chk({tag, "_lastpos"}, 32'(rx_last_idx), 32'(exp_q.size() - 1));
        s = 32'h0;
        foreach (rx_q[i]) s = s + rx_q[i];
        chk({tag, "_sum"}, s, 32'h0);
        exp_frames++;
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        chk({tag, "_valid_after"}, 32'(tx_valid), 32'd0);
    endtask

    task automatic run_burst(input string tag, input int n, input bit fixed);
        rx_q.delete();
        drive_burst(n, fixed);
        make_exp(n, 8'(exp_frames));
        wait_last(tag, 600);
        check_packet(tag);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_last", 32'(tx_last), 32'd0);
        chk("rst_data", tx_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame", 32'(frame_cnt), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        @(posedge clk); #1;
        Reset = 1'b0;

        // T1: fixed 4-beat burst, ready high, no bubbles
        rmode = 0;
        run_burst("t1", 4, 1'b1);
        chk("t1_hdr", rx_q[0], 32'hA5010400);
        chk("t1_gapless", 32'(last_cyc - first_cyc + 1), 32'd8);

        // T2: same burst, ready 1,0,0 pattern
        rmode = 1; phase = 0;
        run_burst("t2", 4, 1'b1);
        rmode = 0;

        // T3: 20 beats truncated to MAX_WORDS
        run_burst("t3", 20, 1'b0);
        chk("t3_overrun", 32'(overrun_cnt), 32'd0);

        // T4: second burst while first stalled
        begin
            int k;
            rmode = 3;
            rx_q.delete();
            drive_burst(4, 1'b0);
            make_exp(4, 8'(exp_frames));
            k = 0;
            while (tx_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
            chk("t4_stall_valid", 32'(tx_valid), 32'd1);
            bx = $urandom; by = $urandom;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                LocalDataValid = 1'b1; LocalCountData = $urandom; LocalBpmPosData = $urandom;
            end
            @(posedge clk); #1;
            LocalDataValid = 1'b0;
            @(negedge clk);
            chk("t4_overrun", 32'(overrun_cnt), 32'd1);
            chk("t4_busy", 32'(busy), 32'd1);
            rmode = 0;
            wait_last("t4", 200);
            check_packet("t4");
            repeat (30) @(negedge clk);
            chk("t4_no_second", 32'(rx_q.size()), 32'(exp_q.size()));
            chk("t4_idle", 32'(busy), 32'd0);
        end

        // T5: single beat, then a disabled burst
        run_burst("t5", 1, 1'b0);
        chk("t5_ywzero", rx_q[2], 32'h0);
        rx_q.delete();
        Enable = 1'b0;
        drive_burst(3, 1'b0);
        repeat (30) @(negedge clk);
        chk("t5_dis_words", 32'(rx_q.size()), 32'd0);
        chk("t5_dis_frame", 32'(frame_cnt), 32'(exp_frames));
        chk("t5_dis_overrun", 32'(overrun_cnt), 32'd1);
        chk("t5_dis_busy", 32'(busy), 32'd0);
        Enable = 1'b1;

        // random bursts, random back-pressure
        for (int t = 0; t < 8; t++) begin
            rmode = ((t % 2) == 0) ? 2 : 0;
            run_burst($sformatf("rnd%0d", t), int'($urandom_range(1, 20)), 1'b0);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        rmode = 0;

        // T6: reset during payload
        begin
            int k;
            rx_q.delete();
            drive_burst(6, 1'b0);
            k = 0;
            while (rx_q.size() < 4 && k < 100) begin @(negedge clk); k++; end
            chk("t6_reached_pay", 32'(rx_q.size() >= 4), 32'd1);
            Reset = 1'b1;
            @(negedge clk);
            chk("t6_valid", 32'(tx_valid), 32'd0);
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_frame", 32'(frame_cnt), 32'd0);
            chk("t6_overrun", 32'(overrun_cnt), 32'd0);
            @(posedge clk); #1;
            Reset = 1'b0;
            exp_frames = 0;
            run_burst("t6_after", 5, 1'b0);
            chk("t6_hdr_frame", 32'(rx_q[0][7:0]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
